// File: rtl/vector_mac_stream.sv
// N-lane signed Q-format multiply-add stream engine with per-packet
// accumulation, credit-gated input and a first-word-fall-through output FIFO.
module vector_mac_stream #(
  parameter int BITWIDTH = 16,
  parameter int N        = 8,
  parameter int FRAC     = 8,
  parameter int LAT      = 3,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N*BITWIDTH-1:0] s_in0,
  input  logic [N*BITWIDTH-1:0] s_in1,
  input  logic [N*BITWIDTH-1:0] s_in2,
  input  logic [1:0]            s_mode,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [N*BITWIDTH-1:0] m_out,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  sat_clr,
  output logic                  sat_sticky
);

  localparam int W  = BITWIDTH;
  localparam int VW = N * W;
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;
  localparam int DL = LAT - 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1) + 1;

  localparam logic signed [SW-1:0] SMAX =
    {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    M_ADD = 2'd0,
    M_SUB = 2'd1,
    M_ACC = 2'd2,
    M_MUL = 2'd3
  } mode_t;

  logic          accept;
  logic          produce;
  logic          in_pkt;
  mode_t         pkt_mode;
  mode_t         eff_mode;

  logic          s1_val;
  logic [VW-1:0] s1_a;
  logic [VW-1:0] s1_b;
  logic [VW-1:0] s1_c;
  mode_t         s1_mode;
  logic          s1_first;
  logic          s1_last;

  logic [VW-1:0] acc_q;
  logic [VW-1:0] acc_d;
  logic          acc_satq;
  logic [VW-1:0] res;
  logic          res_val;
  logic          res_sat;
  logic [N-1:0]  lane_sat;

  logic signed [PW-1:0] ea   [N];
  logic signed [PW-1:0] eb   [N];
  logic signed [PW-1:0] prod [N];
  logic signed [SW-1:0] ec   [N];
  logic signed [SW-1:0] eacc [N];
  logic signed [SW-1:0] sum  [N];

  logic          d_val  [DL];
  logic          d_last [DL];
  logic          d_sat  [DL];
  logic [VW-1:0] d_data [DL];

  logic          push;
  logic          pop;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [VW:0]   mem [DEPTH];

  assign accept   = s_valid && s_ready;
  assign eff_mode = in_pkt ? pkt_mode : mode_t'(s_mode);
  assign produce  = (eff_mode != M_ACC) || s_last;

  // Mode is latched on the opening beat and held until the last one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_pkt   <= 1'b0;
      pkt_mode <= M_ADD;
    end else if (accept) begin
      in_pkt <= !s_last;
      if (!in_pkt) pkt_mode <= mode_t'(s_mode);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_val   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_mode  <= M_ADD;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_val <= accept;
      if (accept) begin
        s1_a     <= s_in0;
        s1_b     <= s_in1;
        s1_c     <= s_in2;
        s1_mode  <= eff_mode;
        s1_first <= !in_pkt;
        s1_last  <= s_last;
      end
    end
  end

  always_comb begin
    res      = '0;
    acc_d    = acc_q;
    lane_sat = '0;
    for (int i = 0; i < N; i++) begin
      ea[i]   = PW'($signed(s1_a[i*W +: W]));
      eb[i]   = PW'($signed(s1_b[i*W +: W]));
      prod[i] = (ea[i] * eb[i]) >>> FRAC;
      ec[i]   = SW'($signed(s1_c[i*W +: W]));
      eacc[i] = SW'($signed(acc_q[i*W +: W]));
      sum[i]  = SW'(prod[i]);
      unique case (s1_mode)
        M_ADD: sum[i] = ec[i] + SW'(prod[i]);
        M_SUB: sum[i] = SW'(prod[i]) - ec[i];
        M_ACC: sum[i] = (s1_first ? ec[i] : eacc[i]) + SW'(prod[i]);
        M_MUL: sum[i] = SW'(prod[i]);
      endcase
      if (sum[i] > SMAX) begin
        res[i*W +: W] = SMAX[W-1:0];
        lane_sat[i]   = 1'b1;
      end else if (sum[i] < SMIN) begin
        res[i*W +: W] = SMIN[W-1:0];
        lane_sat[i]   = 1'b1;
      end else begin
        res[i*W +: W] = sum[i][W-1:0];
      end
      acc_d[i*W +: W] = res[i*W +: W];
    end
  end

  assign res_val = s1_val && ((s1_mode != M_ACC) || s1_last);
  // A clamp on an earlier beat of a reduction still flags the packet.
  assign res_sat = (|lane_sat) ||
                   ((s1_mode == M_ACC) && !s1_first && acc_satq);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q    <= '0;
      acc_satq <= 1'b0;
    end else if (s1_val && (s1_mode == M_ACC)) begin
      acc_q    <= acc_d;
      acc_satq <= (|lane_sat) || (!s1_first && acc_satq);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DL; i++) begin
        d_val[i]  <= 1'b0;
        d_last[i] <= 1'b0;
        d_sat[i]  <= 1'b0;
        d_data[i] <= '0;
      end
    end else begin
      d_val[0]  <= res_val;
      d_last[0] <= s1_last;
      d_sat[0]  <= res_sat;
      d_data[0] <= res;
      for (int i = 1; i < DL; i++) begin
        d_val[i]  <= d_val[i-1];
        d_last[i] <= d_last[i-1];
        d_sat[i]  <= d_sat[i-1];
        d_data[i] <= d_data[i-1];
      end
    end
  end

  assign push    = d_val[DL-1];
  assign m_valid = (fifo_cnt != '0);
  assign pop     = m_valid && m_ready;

  // Credits cover both queued and in-flight results, so the FIFO
  // can never overflow regardless of downstream stalls.
  assign s_ready = rstn && ((fifo_cnt + inflight) < CW'(DEPTH));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= inflight + CW'(accept && produce) - CW'(push);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {d_last[DL-1], d_data[DL-1]};
  end

  assign m_out  = m_valid ? mem[rd_ptr][VW-1:0] : '0;
  assign m_last = m_valid && mem[rd_ptr][VW];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      sat_sticky <= 1'b0;
    else if (push && d_sat[DL-1])
      sat_sticky <= 1'b1;
    else if (sat_clr)
      sat_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_vector_mac_stream.sv
// Scoreboard bench for vector_mac_stream: directed beats push expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_vector_mac_stream;

  localparam int W     = 16;
  localparam int N     = 8;
  localparam int FRAC  = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int VW    = N * W;

  logic          clk;
  logic          rstn;
  logic [VW-1:0] s_in0;
  logic [VW-1:0] s_in1;
  logic [VW-1:0] s_in2;
  logic [1:0]    s_mode;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [VW-1:0] m_out;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          sat_clr;
  logic          sat_sticky;

  typedef struct {
    logic [VW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   nout;

  vector_mac_stream #(
    .BITWIDTH(W),
    .N(N),
    .FRAC(FRAC),
    .LAT(LAT),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .s_in0(s_in0),
    .s_in1(s_in1),
    .s_in2(s_in2),
    .s_mode(s_mode),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .m_out(m_out),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .sat_clr(sat_clr),
    .sat_sticky(sat_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] rep(input logic [W-1:0] x);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = x;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act,
                     input logic [VW-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      tests++;
      nout++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: got %h want none", m_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (m_out !== e.d || m_last !== e.l) begin
          fails++;
          $display("FAIL result: got %h last %b want %h last %b",
                   m_out, m_last, e.d, e.l);
        end
      end
    end
  end

  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b,
                      input logic [VW-1:0] c, input logic [1:0] md,
                      input logic lst, input logic exp_on,
                      input logic [VW-1:0] ev);
    logic ok;
    s_in0   = a;
    s_in1   = b;
    s_in2   = c;
    s_mode  = md;
    s_last  = lst;
    s_valid = 1'b1;
    ok      = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (exp_on) sb.push_back('{d: ev, l: lst});
      @(posedge clk);
      #1;
    end else begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got s_ready 0 want 1");
    end
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] a7;
    logic [VW-1:0] b7;
    logic [VW-1:0] c7;
    logic [VW-1:0] e7;
    int            lat_cnt;
    int            n0;
    int            acc;
    logic          r;

    tests   = 0;
    fails   = 0;
    nout    = 0;
    rstn    = 1'b0;
    s_in0   = '0;
    s_in1   = '0;
    s_in2   = '0;
    s_mode  = 2'd0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    sat_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", VW'(s_ready), '0);
    chk("rst_m_valid", VW'(m_valid), '0);
    chk("rst_m_last", VW'(m_last), '0);
    chk("rst_m_out", m_out, '0);
    chk("rst_sticky", VW'(sat_sticky), '0);
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", VW'(s_ready), VW'(1));

    // Mode 0 single beat and its latency
    send(rep(16'h0180), rep(16'h0200), rep(16'h0040), 2'd0, 1'b1,
         1'b1, rep(16'h0340));
    idle();
    lat_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        lat_cnt = c;
        break;
      end
    end
    chk("latency", VW'(lat_cnt), VW'(LAT));
    drain();

    // Modes 1 and 3, then per-lane independence
    send(rep(16'h0180), rep(16'h0200), rep(16'h0040), 2'd1, 1'b1,
         1'b1, rep(16'h02C0));
    send(rep(16'h0180), rep(16'h0200), rep(16'h0040), 2'd3, 1'b1,
         1'b1, rep(16'h0300));
    a7 = rep(16'h0180);
    b7 = rep(16'h0200);
    c7 = rep(16'h0040);
    e7 = rep(16'h0340);
    a7[7*W +: W] = 16'hFF00;
    b7[7*W +: W] = 16'h0100;
    c7[7*W +: W] = 16'h00C0;
    e7[7*W +: W] = 16'hFFC0;
    send(a7, b7, c7, 2'd0, 1'b1, 1'b1, e7);
    idle();
    drain();
    chk("no_sat_yet", VW'(sat_sticky), '0);

    // Saturation, sticky clear, negative clamp
    send(rep(16'h7FFF), rep(16'h7FFF), rep(16'h0000), 2'd0, 1'b1,
         1'b1, rep(16'h7FFF));
    idle();
    drain();
    chk("sticky_set", VW'(sat_sticky), VW'(1));
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sticky_clr", VW'(sat_sticky), '0);
    send(rep(16'h8000), rep(16'h7FFF), rep(16'h0000), 2'd0, 1'b1,
         1'b1, rep(16'h8000));
    idle();
    drain();
    chk("sticky_neg", VW'(sat_sticky), VW'(1));

    // Mode 2 packet with a mid-packet mode change
    n0 = nout;
    send(rep(16'h0100), rep(16'h0100), rep(16'h0010), 2'd2, 1'b0,
         1'b0, '0);
    send(rep(16'h0100), rep(16'h0100), rep(16'h7777), 2'd2, 1'b0,
         1'b0, '0);
    send(rep(16'h0100), rep(16'h0100), rep(16'h7777), 2'd0, 1'b0,
         1'b0, '0);
    send(rep(16'h0100), rep(16'h0100), rep(16'h7777), 2'd0, 1'b1,
         1'b1, rep(16'h0410));
    idle();
    drain();
    chk("acc_count", VW'(nout - n0), VW'(1));

    // Backpressure: credits stop input at DEPTH
    n0 = nout;
    m_ready = 1'b0;
    acc = 0;
    s_in1   = rep(16'h0100);
    s_in2   = rep(16'h0001);
    s_mode  = 2'd0;
    s_last  = 1'b1;
    s_in0   = rep(W'(16'h0100 + acc));
    s_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = s_ready;
      if (r) sb.push_back('{d: rep(W'(16'h0101 + acc)), l: 1'b1});
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        s_in0 = rep(W'(16'h0100 + acc));
      end
    end
    chk("bp_accepted", VW'(acc), VW'(DEPTH));
    chk("bp_ready_low", VW'(s_ready), '0);
    chk("bp_hold_out", m_out, rep(16'h0101));
    chk("bp_hold_last", VW'(m_last), VW'(1));
    m_ready = 1'b1;
    for (int k = DEPTH; k < DEPTH + 6; k++)
      send(rep(W'(16'h0100 + k)), rep(16'h0100), rep(16'h0001), 2'd0,
           1'b1, 1'b1, rep(W'(16'h0101 + k)));
    idle();
    drain();
    chk("bp_total", VW'(nout - n0), VW'(DEPTH + 6));

    // Reset in the middle of a reduction packet
    send(rep(16'h0100), rep(16'h0100), rep(16'h0055), 2'd2, 1'b0,
         1'b0, '0);
    send(rep(16'h0100), rep(16'h0100), rep(16'h0055), 2'd2, 1'b0,
         1'b0, '0);
    idle();
    rstn = 1'b0;
    #2;
    chk("mid_rst_ready", VW'(s_ready), '0);
    chk("mid_rst_valid", VW'(m_valid), '0);
    chk("mid_rst_last", VW'(m_last), '0);
    chk("mid_rst_out", m_out, '0);
    chk("mid_rst_sticky", VW'(sat_sticky), '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk("rel_ready", VW'(s_ready), VW'(1));
    n0 = nout;
    send(rep(16'h0100), rep(16'h0100), rep(16'h0000), 2'd2, 1'b1,
         1'b1, rep(16'h0100));
    idle();
    drain();
    chk("post_rst_count", VW'(nout - n0), VW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vector_mac_stream.md
# vector_mac_stream

Parametrised N-lane signed fixed-point fused multiply-add engine with a full valid/ready stream handshake on both sides, per-beat mode selection and per-packet dot-product accumulation. Successor to the fixed-latency, non-stallable vector multiply-add stage in the vector datapath. It adds backpressure via credit-tracked output buffering, saturation with a sticky flag, and a reduction mode, so it can sit directly between the stream DMA and downstream normalisation logic.

## Interface

- `BITWIDTH`, 16: lane width, signed two's complement; ≥4.
- `N`, 8: lanes per beat; ≥1.
- `FRAC`, 8: fractional bits of the Q format; 0 ≤ FRAC < BITWIDTH.
- `LAT`, 3: pipeline depth from accept to result; ≥2.
- `DEPTH`, 4: output FIFO entries; ≥2.

Ports:

- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low; synchronous deassert is handled outside the block.
- `s_in0`, `s_in1`, `s_in2`  in  N*BITWIDTH each  operands a, b, c; lane i is `[i*BITWIDTH +: BITWIDTH]`.
- `s_mode`  in  2  operating mode: 0 = a*b+c, 1 = a*b−c, 2 = accumulate, 3 = a*b.
- `s_valid`  in  1  input beat valid.
- `s_last`  in  1  last beat of packet.
- `s_ready`  out  1  block accepts a beat this cycle.
- `m_out`  out  N*BITWIDTH  result lanes.
- `m_valid`  out  1  result valid.
- `m_last`  out  1  last result of packet.
- `m_ready`  in  1  downstream accepts.
- `sat_clr`  in  1  clears `sat_sticky`.
- `sat_sticky`  out  1  a saturation has occurred since reset or the last clear.

## Operation

**Beat acceptance**
- A beat is accepted on a rising edge where `s_valid && s_ready`.
- Lanes share the handshake. They never diverge in timing.

**Arithmetic, per lane**
- p = (a*b) as a 2*BITWIDTH signed product, arithmetic-shifted right by FRAC (floor).
- Sum is formed at full width, then saturated to [−2^(BITWIDTH−1), 2^(BITWIDTH−1)−1].
- Any lane clamping sets `sat_sticky` on the edge the result enters the FIFO.

**Modes**
- Modes 0, 1, 3 produce one result per beat. `m_last` equals `s_last` of that beat.
- Mode 2 (accumulate):
  - First beat of a packet: acc = sat(c + p).
  - Later beats: acc = sat(acc + p). `s_in2` is ignored.
  - Only the `s_last` beat produces a result, with `m_last`=1. Non-last beats produce nothing.
- Mode is sampled on the first beat of a packet and held until its `s_last` beat. A change of `s_mode` mid-packet is ignored.
- A single beat with `s_last`=1 is a complete packet.

**Credit tracking**
- `inflight` counts accepted beats in the pipeline that will produce a result.
- `fifo_cnt` counts FIFO occupancy.
- `s_ready` = (fifo_cnt + inflight) < DEPTH, decoded from registers only (no combinational path from `m_ready`).
- A pop frees a credit on the following cycle. This guarantees the FIFO never overflows and no result is dropped.

**FIFO**
- First-word-fall-through.
- Push and pop in the same cycle leave `fifo_cnt` unchanged.
- Results leave in accept order.

**Sticky flag**
- `sat_clr` clears `sat_sticky`.
- If `sat_clr` and a new saturation occur in the same cycle, the flag ends set.

**Reset (`rstn`=0)**
- Pipeline, accumulators, in-packet flag, counters and FIFO are cleared.
- Outputs: `s_ready`=0 during reset and 1 on the first cycle after; `m_valid`=0, `m_last`=0, `m_out`=0, `sat_sticky`=0.
- A packet interrupted by reset is discarded. The next accepted beat starts a new packet.

## Timing

- Latency: a beat accepted at edge k is written to the FIFO at edge k+LAT. With the FIFO empty, `m_valid` is high in the cycle after edge k+LAT.
- Throughput: one beat per cycle while `m_ready`=1 and DEPTH ≥ LAT+1. A smaller DEPTH throttles throughput by credits, never by dropping results.
- `m_out`/`m_last` are held stable while `m_valid && !m_ready`.
- Mode-2 non-last beats consume no credit.

## Test plan

- Mode 0, B=16, FRAC=8: a=0x0180, b=0x0200, c=0x0040, `s_last`=1 → `m_out` lane = 0x0340, `m_last`=1, `m_valid` exactly LAT cycles after accept.
- Mode 1 with the same operands → 0x02C0. Mode 3 → 0x0300. Lane-independence check: lane 0 = 0x0340 while lane 7 = 0xFFC0 (a=−1.0, b=1.0, c=0.75).
- Saturation: a=b=0x7FFF, c=0 → 0x7FFF and `sat_sticky`=1. Then `sat_clr` pulsed → 0. Negative clamp: a=0x8000, b=0x7FFF → 0x8000.
- Mode 2: 4 beats of a=b=0x0100, first-beat c=0x0010, `s_mode` toggled to 0 on beat 3 → exactly one result 0x0410 with `m_last`=1.
- Backpressure, DEPTH=4: `m_ready`=0 with continuous valid mode-0 input → exactly 4 beats accepted, then `s_ready`=0. Release `m_ready` → 4 results in order, then streaming resumes with no loss or duplication.
- Reset mid mode-2 packet after 2 beats, then a fresh 1-beat packet with a=b=0x0100, c=0 → 0x0100. No residue from the aborted accumulation; all outputs are 0 during reset.
